cache_arbiter: RTL and testbench

- Shares the single line-granular physical memory port (to the cacheline adaptor / burst memory) between the instruction cache and the data cache of the mp4 pipeline.
- Serialises one line transaction at a time.
- Latches the winning request's address and write data, and routes the response back to the winner only.
- Round-robin on simultaneous requests, so a dcache miss loop cannot starve instruction fetch.

---
 rtl/cache_arbiter_pkg.sv | 20 ++
 rtl/cache_arbiter_rr_select2.sv | 24 ++
 rtl/cache_arbiter.sv | 114 +++++++++++
 tb/tb_cache_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the icache/dcache line-port arbiter.
// Holds the FSM and requester encodings plus the default line and address widths.
package cache_arbiter_pkg;

    localparam int unsigned ARB_LINE_W = 256;
    localparam int unsigned ARB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage

// File: rtl/cache_arbiter_rr_select2.sv
// Two-way round-robin picker: a lone requester always wins, and on a tie the
// requester that was not granted last wins.
module rr_select2
    import cache_arbiter_pkg::*;
(
    input  logic       req_i_i,
    input  logic       req_d_i,
    input  requester_t last_grant_i,
    output logic       grant_valid_o,
    output requester_t grant_id_o
);

    always_comb begin
        grant_valid_o = req_i_i | req_d_i;
        if (req_i_i && req_d_i) begin
            grant_id_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d_i) begin
            grant_id_o = REQ_D;
        end else begin
            grant_id_o = REQ_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-granular memory port between icache and dcache, serving one
// latched line transaction at a time with round-robin on ties.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = ARB_LINE_W,
    parameter int unsigned ADDR_W = ARB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    // Handshake: a cache holds its request until its x_resp pulse and requests
    // are only sampled in IDLE; downstream, mem_read/mem_write with addr/wdata
    // stay stable from the grant until the mem_resp cycle, which ends the
    // transaction. DONE gives the served cache a cycle to drop its request.

    arb_state_t  state_q, state_d;
    requester_t  last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;

    logic       grant_valid;
    requester_t grant_id;
    logic       serving;

    rr_select2 u_rr_select2 (
        .req_i_i       (i_read),
        .req_d_i       (d_read | d_write),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant_id;
                    if (grant_id == REQ_D) begin
                        state_d = SERVE_D;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        // A simultaneous read+write is treated as the write-back.
                        write_d = d_write;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = i_addr;
                        wdata_d = '0;
                        write_d = 1'b0;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        serving   = (state_q == SERVE_I) || (state_q == SERVE_D);
        mem_read  = serving & ~write_q;
        mem_write = serving & write_q;
        mem_addr  = serving ? addr_q : '0;
        mem_wdata = serving ? wdata_q : '0;
        i_resp    = (state_q == SERVE_I) & mem_resp;
        d_resp    = (state_q == SERVE_D) & mem_resp;
        i_rdata   = i_resp ? mem_rdata : '0;
        d_rdata   = d_resp ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized self-checking bench for cache_arbiter: a transaction-level model
// predicts grant order, latched fields and response routing for each round.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk;
    logic          reset_n;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    cache_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    typedef struct {
        logic          is_d;
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    logic model_last_d;
    int   n_checks;
    int   n_pass;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = $urandom;
        a[4:0] = 5'd0;
        return a;
    endfunction

    // Driver tasks
    task automatic drop_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        mem_resp = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drop_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_last_d = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle_gap(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            mem_resp  = 1'($urandom_range(0, 1));
            mem_rdata = rand_line();
            #1;
            check("idle_resp", {i_resp, d_resp}, 2'b00);
            check("idle_mem", {mem_read, mem_write}, 2'b00);
        end
    endtask

    task automatic run_round(input bit ri, input bit dr, input bit dw,
                             input logic [AW-1:0] ia, input logic [AW-1:0] da,
                             input logic [LW-1:0] dwd, input bit scramble,
                             input int dly_fix, input bit use_rd, input logic [LW-1:0] rd_fix);
        txn_t t_i, t_d, t;
        int   n, lat, dly;
        logic [LW-1:0] rd;
        t_i = '{1'b0, ia, 1'b0, '0};
        t_d = '{1'b1, da, dw, dwd};
        if (ri && (dr || dw)) begin
            // Tie: whoever was not served last goes first, then the other.
            if (model_last_d) begin exp_q.push_back(t_i); exp_q.push_back(t_d); end
            else begin exp_q.push_back(t_d); exp_q.push_back(t_i); end
        end else if (ri) exp_q.push_back(t_i);
        else if (dr || dw) exp_q.push_back(t_d);

        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = rand_line();
        i_read = ri; i_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = dwd;
        #1;
        check("idle_quiet", {mem_read, mem_write}, 2'b00);
        lat = 1;
        while (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            n = 0;
            forever begin
                @(negedge clk);
                mem_resp = 1'b0;
                n++;
                if (mem_read || mem_write || n >= 8) break;
                mem_resp  = 1'($urandom_range(0, 1));
                mem_rdata = rand_line();
                #1;
                check("wait_no_resp", {i_resp, d_resp}, 2'b00);
            end
            check("grant_latency", n, lat);
            if (!(mem_read || mem_write)) begin
                do_reset();
                return;
            end
            model_last_d = t.is_d;
            check("mem_addr", mem_addr, t.addr);
            check("mem_op", {mem_read, mem_write}, {~t.wr, t.wr});
            if (t.wr) check("mem_wdata", mem_wdata, t.wdata);

            dly = (dly_fix >= 0) ? dly_fix : $urandom_range(0, 4);
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                mem_rdata = rand_line();
                if (scramble) begin
                    if (t.is_d) begin
                        d_addr = $urandom; d_wdata = rand_line();
                        {d_read, d_write} = 2'($urandom_range(0, 3));
                    end else begin
                        i_addr = $urandom; i_read = 1'($urandom_range(0, 1));
                    end
                end
                #1;
                check("hold_addr", mem_addr, t.addr);
                check("hold_op", {mem_read, mem_write}, {~t.wr, t.wr});
                if (t.wr) check("hold_wdata", mem_wdata, t.wdata);
                check("hold_no_resp", {i_resp, d_resp}, 2'b00);
                check("hold_rdata_zero", i_rdata | d_rdata, '0);
            end

            @(negedge clk);
            rd = use_rd ? rd_fix : rand_line();
            mem_resp = 1'b1; mem_rdata = rd;
            #1;
            check("resp_addr", mem_addr, t.addr);
            check("resp_win", t.is_d ? d_resp : i_resp, 1'b1);
            check("rdata_win", t.is_d ? d_rdata : i_rdata, rd);
            check("resp_lose", t.is_d ? i_resp : d_resp, 1'b0);
            check("rdata_lose", t.is_d ? i_rdata : d_rdata, '0);

            @(negedge clk);
            mem_resp = 1'($urandom_range(0, 1));
            mem_rdata = rand_line();
            if (t.is_d) begin d_read = 1'b0; d_write = 1'b0; end
            else i_read = 1'b0;
            #1;
            check("done_mem", {mem_read, mem_write}, 2'b00);
            check("done_resp", {i_resp, d_resp}, 2'b00);
            lat = 2;
        end
    endtask

    task automatic reset_mid_serve();
        do_reset();
        @(negedge clk);
        i_read = 1'b1; i_addr = 32'h100; d_read = 1'b1; d_write = 1'b0; d_addr = 32'h200;
        @(negedge clk);
        check("rst_pre_addr", mem_addr, 32'h200);
        check("rst_pre_read", mem_read, 1'b1);
        #2;
        mem_resp = 1'b1;
        reset_n  = 1'b0;
        #1;
        check("rst_async_op", {mem_read, mem_write}, 2'b00);
        check("rst_async_resp", {i_resp, d_resp}, 2'b00);
        check("rst_async_addr", mem_addr, '0);
        drop_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_last_d = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int pat, op, gap;
        bit ri, dr, dw;
        n_checks = 0; n_pass = 0;
        model_last_d = 1'b0;
        reset_n = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        drop_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_op", {mem_read, mem_write}, 2'b00);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
        check("rst_rdata", i_rdata | d_rdata, '0);
        @(negedge clk);
        reset_n = 1'b1;

        run_round(1, 0, 0, 32'h60, 32'h0, '0, 0, 3, 1, {32{8'hA5}});
        run_round(1, 1, 0, 32'h100, 32'h200, '0, 0, -1, 0, '0);
        run_round(1, 1, 0, 32'h140, 32'h240, '0, 0, -1, 0, '0);
        run_round(0, 0, 1, 32'h0, 32'h400, {8{32'hDEADBEEF}}, 0, 3, 0, '0);
        run_round(1, 0, 0, 32'h60, 32'h0, '0, 1, 3, 0, '0);
        idle_gap(3);
        run_round(0, 1, 1, 32'h0, 32'h300, {8{32'h1234_5678}}, 0, 1, 0, '0);
        reset_mid_serve();
        run_round(1, 1, 0, 32'h100, 32'h200, '0, 0, -1, 0, '0);

        for (int r = 0; r < 150; r++) begin
            pat = $urandom_range(1, 3);
            op  = $urandom_range(0, 2);
            ri  = pat[0];
            dr  = pat[1] && (op != 1);
            dw  = pat[1] && (op != 0);
            run_round(ri, dr, dw, rand_addr(), rand_addr(), rand_line(),
                      1'($urandom_range(0, 1)), -1, 0, '0);
            gap = $urandom_range(0, 2);
            idle_gap(gap);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
